prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side checker for the on-chip 8-bit PRBS stream (x^8+x^6+x^5+x^4+1).
//  Self-synchronising: predicts each incoming bit from the last 8 received bits,
//  acquires lock, and counts bit errors once locked. It sits beside the output
//  mux so the generator's serial stream can be looped back and verified on-chip.
// PARAMETERS
//  LOCK_COUNT   16   consecutive matching bits in CHECK required to declare lock
//  WINDOW       64   valid bits per loss-of-lock observation window (LOCKED only)
//  UNLOCK_ERRS  16   errors within one window that force loss of lock
// PORTS
//  clk         in   1  single clock, all state updates on rising edge
//  reset_n     in   1  synchronous, active-low reset
//  data_in     in   1  received serial PRBS bit
//  data_valid  in   1  data_in is sampled only when high
//  clear       in   1  zero err_count (state and lock unaffected)
//  locked      out  1  high while in LOCKED
//  mismatch    out  1  one-cycle pulse: valid bit differed from prediction (CHECK/LOCKED)
//  err_count   out  8  saturating error count, counts in LOCKED only
//  state       out  2  debug: 00 SEED, 01 CHECK, 10 LOCKED
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state=SEED, history h=0, all counters 0,
//    locked=0, mismatch=0, err_count=0. Reset mid-stream discards everything.
//  - All outputs are registered. Nothing changes on cycles with data_valid=0,
//    except mismatch (returns to 0) and the clear action.
//  - Every valid bit: predicted p = h[7]^h[5]^h[4]^h[3] (h before update);
//    then h <= {h[6:0], data_in}, in every state.
//  - SEED: count 8 valid bits; at the edge of the 8th -> CHECK, match_cnt=0.
//  - CHECK: data_in==p and h!=0 -> match_cnt++; on reaching LOCK_COUNT -> LOCKED
//    (locked rises on that edge). Mismatch or h==0 -> match_cnt=0, stay in CHECK.
//  - LOCKED: a mismatch increments err_count (saturates at 255, no wrap) and
//    win_errs. win_cnt counts valid bits 0..WINDOW-1. Wrap clears win_errs;
//    an error on the wrap bit starts the new window at win_errs=1.
//    win_errs reaching UNLOCK_ERRS, or h==0 after the update -> SEED, locked=0
//    on that edge. err_count keeps its value across loss of lock.
//  - A single flipped line bit yields exactly 5 mismatches (the bit itself, then
//    once each as it passes h[3], h[4], h[5], h[7]).
//  - clear and an error on the same edge: clear wins (err_count=0).
//    clear while err_count=255 -> 0.
//  - Latency: mismatch and err_count reflect a bit on the edge that samples it.
// STRUCTURE
//  - Shared package prbs_pkg: state encoding constants (SEED/CHECK/LOCKED),
//    PRBS8 tap mask 8'hB8, PRBS width 8. The generator must use the same package.
//  - One sub-module: sat_counter (WIDTH param, inc, clr, saturating), used for
//    err_count; match_cnt, win_cnt and win_errs stay inline.
// TESTING
//  1 Reset, then stream from generator seeded 8'h01, data_valid=1 every cycle
//    -> state 00->01 after bit 8, locked=1 after bit 24, err_count=0, no mismatch.
//  2 While locked, invert one bit -> exactly 5 mismatch pulses, err_count=5,
//    locked stays 1.
//  3 While locked, drive 16 random-inverted bits within one window
//    -> locked drops to 0, state=00 at the 16th error, err_count holds its value.
//  4 Constant 0 input after reset -> never leaves CHECK, locked stays 0.
//    Constant 0 injected while locked -> back to SEED once h==0.
//  5 Force 300 errors -> err_count sticks at 255. Assert clear on the same
//    cycle as an error -> err_count=0.
//  6 Gap data_valid (1 of 3 cycles) -> lock after 24 valid bits.
//    Pulse reset_n=0 mid-lock -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS8 definitions for the on-chip generator and checker.
// Polynomial x^8+x^6+x^5+x^4+1, newest bit kept in bit 0 of the history.
package prbs_pkg;

   localparam int PRBS_W = 8;
   localparam logic [PRBS_W-1:0] PRBS_TAPS = 8'hB8;

   localparam logic [1:0] ST_SEED   = 2'b00;
   localparam logic [1:0] ST_CHECK  = 2'b01;
   localparam logic [1:0] ST_LOCKED = 2'b10;

   // Next PRBS bit predicted from the last PRBS_W bits.
   function automatic logic prbs_next(input logic [PRBS_W-1:0] h);
      return ^(h & PRBS_TAPS);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over increment on the same edge.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS8 receive checker.
// Seeds history from the line, checks for lock, then counts bit errors.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_COUNT  = 16,
   parameter int WINDOW      = 64,
   parameter int UNLOCK_ERRS = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       data_in,
   input  logic       data_valid,
   input  logic       clear,
   output logic       locked,
   output logic       mismatch,
   output logic [7:0] err_count,
   output logic [1:0] state
);

   localparam int SD_W = $clog2(PRBS_W);
   localparam int MC_W = $clog2(LOCK_COUNT + 1);
   localparam int WC_W = $clog2(WINDOW);
   localparam int WE_W = $clog2(UNLOCK_ERRS + 1);

   logic [1:0]        state_q, state_d;
   logic [PRBS_W-1:0] h_q, h_d;
   logic [SD_W-1:0]   seed_cnt_q, seed_cnt_d;
   logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
   logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
   logic [WE_W-1:0]   win_errs_q, win_errs_d;
   logic              locked_q, locked_d;
   logic              mismatch_q, mismatch_d;

   logic              pred;
   logic              bit_err;
   logic              err_inc;
   logic [PRBS_W-1:0] h_nxt;
   logic [WE_W-1:0]   werr_nxt;

   assign pred    = prbs_next(h_q);
   assign bit_err = data_in ^ pred;
   assign h_nxt   = {h_q[PRBS_W-2:0], data_in};

   // Per-valid-bit state machine, history shift and window tracking.
   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      seed_cnt_d  = seed_cnt_q;
      match_cnt_d = match_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_errs_d  = win_errs_q;
      locked_d    = locked_q;
      mismatch_d  = 1'b0;
      err_inc     = 1'b0;
      werr_nxt    = win_errs_q;
      if (data_valid) begin
         h_d = h_nxt;
         unique case (state_q)
            ST_SEED: begin
               if (seed_cnt_q == SD_W'(PRBS_W - 1)) begin
                  state_d     = ST_CHECK;
                  seed_cnt_d  = '0;
                  match_cnt_d = '0;
               end else begin
                  seed_cnt_d = seed_cnt_q + SD_W'(1);
               end
            end
            ST_CHECK: begin
               mismatch_d = bit_err;
               if (!bit_err && (h_q != '0)) begin
                  if (match_cnt_q == MC_W'(LOCK_COUNT - 1)) begin
                     state_d     = ST_LOCKED;
                     locked_d    = 1'b1;
                     match_cnt_d = '0;
                     win_cnt_d   = '0;
                     win_errs_d  = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + MC_W'(1);
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               mismatch_d = bit_err;
               err_inc    = bit_err;
               if (win_cnt_q == WC_W'(WINDOW - 1)) begin
                  win_cnt_d = '0;
                  werr_nxt  = WE_W'(bit_err);
               end else begin
                  win_cnt_d = win_cnt_q + WC_W'(1);
                  werr_nxt  = win_errs_q + WE_W'(bit_err);
               end
               win_errs_d = werr_nxt;
               if ((werr_nxt == WE_W'(UNLOCK_ERRS)) || (h_nxt == '0)) begin
                  state_d    = ST_SEED;
                  locked_d   = 1'b0;
                  seed_cnt_d = '0;
               end
            end
            default: begin
               state_d    = ST_SEED;
               locked_d   = 1'b0;
               seed_cnt_d = '0;
            end
         endcase
      end
   end

   // Checker registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_SEED;
         h_q         <= '0;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         win_cnt_q   <= '0;
         win_errs_q  <= '0;
         locked_q    <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         win_cnt_q   <= win_cnt_d;
         win_errs_q  <= win_errs_d;
         locked_q    <= locked_d;
         mismatch_q  <= mismatch_d;
      end
   end

   sat_counter #(
      .WIDTH (8)
   ) u_err_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (err_inc),
      .clr     (clear),
      .count   (err_count)
   );

   assign locked   = locked_q;
   assign mismatch = mismatch_q;
   assign state    = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker.
// Drives a PRBS8 generator stream with injected faults.
module tb_prbs_checker;

   logic       clk;
   logic       reset_n;
   logic       data_in;
   logic       data_valid;
   logic       clear;
   logic       locked;
   logic       mismatch;
   logic [7:0] err_count;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   logic [7:0] g;

   logic [1:0] m_st;
   logic [7:0] m_h;
   logic       m_mis;
   int         m_seed, m_match, m_win, m_werr, m_raw, m_err;

   prbs_checker dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .clear      (clear),
      .locked     (locked),
      .mismatch   (mismatch),
      .err_count  (err_count),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_st = 2'b00; m_h = 8'h00; m_mis = 1'b0;
      m_seed = 0; m_match = 0; m_win = 0;
      m_werr = 0; m_raw = 0; m_err = 0;
   endtask

   task automatic model_step(input logic v, input logic b, input logic c);
      logic p, e;
      logic [7:0] hn;
      m_mis = 1'b0;
      if (v) begin
         p  = ^(m_h & 8'hB8);
         e  = (b != p);
         hn = {m_h[6:0], b};
         case (m_st)
            2'b00: begin
               if (m_seed == 7) begin
                  m_st = 2'b01; m_seed = 0; m_match = 0;
               end else m_seed++;
            end
            2'b01: begin
               m_mis = e;
               if (!e && m_h != 8'h00) begin
                  if (m_match == 15) begin
                     m_st = 2'b10; m_match = 0; m_win = 0; m_werr = 0;
                  end else m_match++;
               end else m_match = 0;
            end
            default: begin
               m_mis = e;
               if (e) begin
                  m_raw++;
                  if (m_err < 255) m_err++;
               end
               if (m_win == 63) begin
                  m_win = 0; m_werr = int'(e);
               end else begin
                  m_win++; m_werr += int'(e);
               end
               if (m_werr == 16 || hn == 8'h00) begin
                  m_st = 2'b00; m_seed = 0;
               end
            end
         endcase
         m_h = hn;
      end
      if (c) m_err = 0;
   endtask

   task automatic step(input logic v, input logic b, input logic c);
      data_valid = v; data_in = b; clear = c;
      @(posedge clk);
      #1;
      if (!reset_n) model_reset();
      else model_step(v, b, c);
      data_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic gen_bit(output logic b);
      b = ^(g & 8'hB8);
      g = {g[6:0], b};
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic lock_fresh();
      logic b;
      do_reset();
      g = 8'h01;
      for (int i = 0; i < 24; i++) begin
         gen_bit(b); step(1'b1, b, 1'b0);
      end
   endtask

   task automatic test_reset();
      data_in = 1'b0; data_valid = 1'b0; clear = 1'b0;
      do_reset();
      checks++;
      if (state !== 2'b00) begin
         errors++; $display("FAIL reset_state: got %b expected 00", state);
      end
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL reset_locked: got %b expected 0", locked);
      end
      checks++;
      if (mismatch !== 1'b0) begin
         errors++; $display("FAIL reset_mismatch: got %b expected 0", mismatch);
      end
      checks++;
      if (err_count !== 8'd0) begin
         errors++; $display("FAIL reset_err: got %0d expected 0", err_count);
      end
   endtask

   task automatic test_lock();
      logic b;
      do_reset();
      g = 8'h01;
      for (int i = 1; i <= 24; i++) begin
         gen_bit(b); step(1'b1, b, 1'b0);
         checks++;
         if (mismatch !== 1'b0) begin
            errors++; $display("FAIL lock_mis bit %0d: got %b expected 0", i, mismatch);
         end
         if (i == 7) begin
            checks++;
            if (state !== 2'b00) begin
               errors++; $display("FAIL lock_seed7: got %b expected 00", state);
            end
         end
         if (i == 8) begin
            checks++;
            if (state !== 2'b01) begin
               errors++; $display("FAIL lock_check8: got %b expected 01", state);
            end
         end
         if (i == 23) begin
            checks++;
            if (locked !== 1'b0) begin
               errors++; $display("FAIL lock_early23: got %b expected 0", locked);
            end
         end
         if (i == 24) begin
            checks++;
            if (locked !== 1'b1 || state !== 2'b10) begin
               errors++;
               $display("FAIL lock_24: got locked %b state %b expected 1 10", locked, state);
            end
         end
      end
      checks++;
      if (err_count !== 8'd0) begin
         errors++; $display("FAIL lock_err: got %0d expected 0", err_count);
      end
   endtask

   task automatic test_single_flip();
      logic b;
      logic exp_m;
      int pulses;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         gen_bit(b);
         step(1'b1, (i == 2) ? ~b : b, 1'b0);
         exp_m = (i == 2 || i == 6 || i == 7 || i == 8 || i == 10);
         if (mismatch === 1'b1) pulses++;
         checks++;
         if (mismatch !== exp_m) begin
            errors++; $display("FAIL flip_mis bit %0d: got %b expected %b", i, mismatch, exp_m);
         end
      end
      checks++;
      if (pulses != 5) begin
         errors++; $display("FAIL flip_pulses: got %0d expected 5", pulses);
      end
      checks++;
      if (err_count !== 8'd5) begin
         errors++; $display("FAIL flip_err: got %0d expected 5", err_count);
      end
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL flip_locked: got %b expected 1", locked);
      end
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (err_count !== 8'd0 || locked !== 1'b1 || state !== 2'b10) begin
         errors++;
         $display("FAIL clear_idle: got err %0d locked %b state %b expected 0 1 10",
                  err_count, locked, state);
      end
   endtask

   task automatic test_unlock();
      logic b;
      logic [7:0] held;
      bit dropped;
      lock_fresh();
      dropped = 0;
      for (int i = 0; i < 60 && !dropped; i++) begin
         gen_bit(b);
         step(1'b1, (i % 2 == 0) ? ~b : b, 1'b0);
         checks++;
         if (mismatch !== m_mis || state !== m_st) begin
            errors++;
            $display("FAIL unlock_bit %0d: got mis %b st %b expected %b %b",
                     i, mismatch, state, m_mis, m_st);
         end
         if (m_st == 2'b00) dropped = 1;
      end
      checks++;
      if (locked !== 1'b0 || state !== 2'b00) begin
         errors++;
         $display("FAIL unlock_drop: got locked %b state %b expected 0 00", locked, state);
      end
      checks++;
      if (err_count !== 8'(m_err)) begin
         errors++; $display("FAIL unlock_err: got %0d expected %0d", err_count, m_err);
      end
      held = 8'(m_err);
      for (int i = 0; i < 10; i++) begin
         gen_bit(b); step(1'b1, b, 1'b0);
      end
      checks++;
      if (err_count !== held) begin
         errors++; $display("FAIL unlock_hold: got %0d expected %0d", err_count, held);
      end
   endtask

   task automatic test_zero();
      bit dropped;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++;
         if (mismatch !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle bit %0d: got mis %b locked %b expected 0 0",
                     i, mismatch, locked);
         end
      end
      checks++;
      if (state !== 2'b01) begin
         errors++; $display("FAIL zero_check: got %b expected 01", state);
      end
      lock_fresh();
      dropped = 0;
      for (int i = 0; i < 12 && !dropped; i++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++;
         if (mismatch !== m_mis || state !== m_st) begin
            errors++;
            $display("FAIL zero_lock bit %0d: got mis %b st %b expected %b %b",
                     i, mismatch, state, m_mis, m_st);
         end
         if (m_st == 2'b00) dropped = 1;
      end
      checks++;
      if (state !== 2'b00 || locked !== 1'b0) begin
         errors++;
         $display("FAIL zero_seed: got state %b locked %b expected 00 0", state, locked);
      end
   endtask

   task automatic test_saturate();
      logic b;
      int rounds;
      do_reset();
      g = 8'h01;
      rounds = 0;
      while (m_raw < 300 && rounds < 80) begin
         for (int i = 0; i < 24; i++) begin
            gen_bit(b); step(1'b1, b, 1'b0);
         end
         for (int i = 0; i < 30; i++) begin
            gen_bit(b); step(1'b1, ~b, 1'b0);
         end
         rounds++;
      end
      checks++;
      if (m_raw < 300) begin
         errors++; $display("FAIL sat_budget: got %0d errors expected at least 300", m_raw);
      end
      checks++;
      if (err_count !== 8'd255) begin
         errors++; $display("FAIL sat_255: got %0d expected 255", err_count);
      end
      for (int i = 0; i < 60 && m_st != 2'b10; i++) begin
         gen_bit(b); step(1'b1, b, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         gen_bit(b); step(1'b1, b, 1'b0);
      end
      checks++;
      if (locked !== 1'b1 || err_count !== 8'd255) begin
         errors++;
         $display("FAIL sat_relock: got locked %b err %0d expected 1 255", locked, err_count);
      end
      gen_bit(b);
      step(1'b1, ~b, 1'b1);
      checks++;
      if (mismatch !== 1'b1) begin
         errors++; $display("FAIL clr_err_mis: got %b expected 1", mismatch);
      end
      checks++;
      if (err_count !== 8'd0) begin
         errors++; $display("FAIL clr_err_win: got %0d expected 0", err_count);
      end
   endtask

   task automatic test_gap();
      logic b;
      do_reset();
      g = 8'h01;
      for (int i = 1; i <= 24; i++) begin
         gen_bit(b);
         step(1'b1, b, 1'b0);
         step(1'b0, 1'b0, 1'b0);
         checks++;
         if (mismatch !== 1'b0) begin
            errors++; $display("FAIL gap_mis bit %0d: got %b expected 0", i, mismatch);
         end
         step(1'b0, 1'b0, 1'b0);
         if (i == 23) begin
            checks++;
            if (locked !== 1'b0) begin
               errors++; $display("FAIL gap_early: got %b expected 0", locked);
            end
         end
         if (i == 24) begin
            checks++;
            if (locked !== 1'b1 || state !== 2'b10) begin
               errors++;
               $display("FAIL gap_lock: got locked %b state %b expected 1 10", locked, state);
            end
         end
      end
      gen_bit(b);
      step(1'b1, ~b, 1'b0);
      checks++;
      if (mismatch !== 1'b1 || err_count !== 8'd1) begin
         errors++;
         $display("FAIL gap_err: got mis %b err %0d expected 1 1", mismatch, err_count);
      end
      reset_n = 1'b0;
      gen_bit(b);
      step(1'b1, b, 1'b0);
      reset_n = 1'b1;
      checks++;
      if (state !== 2'b00 || locked !== 1'b0 || mismatch !== 1'b0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL midreset: got st %b lk %b mis %b err %0d expected all 0",
                  state, locked, mismatch, err_count);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      model_reset();
      test_reset();
      test_lock();
      test_single_flip();
      test_unlock();
      test_zero();
      test_saturate();
      test_gap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
